// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core types and constants for the writeback path
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_starve_ctr.sv
// wb_starve_ctr: saturating count of consecutive lost arbitrations for one writeback source
module wb_starve_ctr #(
  parameter int LIMIT = 4,
  localparam int W = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_limit
);
  always_comb at_limit = count == W'(LIMIT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clr) count <= '0;
    else if (inc && !at_limit) count <= count + W'(1);
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between ALU and LSU writeback
// LSU wins contention unless the ALU has lost STARVE_LIMIT times in a row.
module regfile_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            wr_en,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;
  logic          at_limit;
  logic          both;
  always_comb begin
    both      = alu_valid && lsu_valid;
    alu_ready = alu_valid && (!lsu_valid || at_limit);
    lsu_ready = lsu_valid && !(alu_valid && at_limit);
  end
  wb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (both && lsu_ready && starve_cnt != CW'(STARVE_LIMIT)),
    .clr      (!alu_valid || alu_ready),
    .count    (starve_cnt),
    .at_limit (at_limit)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_en   <= 1'b0;
      rd_addr <= REG_ZERO;
      rd_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (alu_ready) begin
        wr_en   <= alu_rd != REG_ZERO;
        rd_addr <= alu_rd;
        rd_data <= alu_data;
      end else if (lsu_ready) begin
        wr_en   <= lsu_rd != REG_ZERO;
        rd_addr <= lsu_rd;
        rd_data <= lsu_data;
      end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of grant, starvation, x0 and reset behaviour
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_rd = '0, lsu_rd = '0;
  logic [31:0] alu_data = '0, lsu_data = '0;
  logic        wr_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] rf [32] = '{default: '0};
  int          checks = 0, errors = 0;

  regfile_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wr_en(wr_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (wr_en) rf[rd_addr] <= rd_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_wr_en", {31'b0, wr_en}, 0);
    chk("rst_rd_addr", {27'b0, rd_addr}, 0);
    chk("rst_rd_data", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_wr_en", {31'b0, wr_en}, 0);
    // single ALU source
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    chk("single_alu_ready", {31'b0, alu_ready}, 1);
    chk("single_lsu_ready", {31'b0, lsu_ready}, 0);
    tick();
    alu_valid = 1'b0;
    chk("single_wr_en", {31'b0, wr_en}, 1);
    chk("single_rd_addr", {27'b0, rd_addr}, 5);
    chk("single_rd_data", rd_data, 32'hDEADBEEF);
    tick();
    chk("single_wr_en_drop", {31'b0, wr_en}, 0);
    chk("single_rd_addr_hold", {27'b0, rd_addr}, 5);
    chk("rf_x5", rf[5], 32'hDEADBEEF);
    // contention: LSU first, then ALU
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
    #1;
    chk("cont_lsu_ready", {31'b0, lsu_ready}, 1);
    chk("cont_alu_ready", {31'b0, alu_ready}, 0);
    tick();
    lsu_valid = 1'b0;
    chk("cont_first_addr", {27'b0, rd_addr}, 4);
    chk("cont_first_data", rd_data, 32'h44);
    #1;
    chk("cont_alu_ready2", {31'b0, alu_ready}, 1);
    tick();
    alu_valid = 1'b0;
    chk("cont_second_addr", {27'b0, rd_addr}, 3);
    chk("cont_second_wr_en", {31'b0, wr_en}, 1);
    // starvation: LSU always valid, ALU forced through in cycle 4
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0A0;
    lsu_valid = 1'b1; lsu_rd = 5'd11;
    for (int i = 0; i < 6; i++) begin
      lsu_data = 32'h100 + 32'(i);
      #1;
      chk($sformatf("starve_alu_ready_%0d", i), {31'b0, alu_ready}, (i == 4) ? 1 : 0);
      chk($sformatf("starve_lsu_ready_%0d", i), {31'b0, lsu_ready}, (i == 4) ? 0 : 1);
      tick();
      chk($sformatf("starve_rd_addr_%0d", i), {27'b0, rd_addr}, (i == 4) ? 10 : 11);
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
    chk("rf_x10", rf[10], 32'hA0A0);
    chk("rf_x11", rf[11], 32'h105);
    // write to x0
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1234;
    #1;
    chk("x0_lsu_ready", {31'b0, lsu_ready}, 1);
    tick();
    lsu_valid = 1'b0;
    chk("x0_wr_en", {31'b0, wr_en}, 0);
    chk("x0_rd_addr", {27'b0, rd_addr}, 0);
    chk("x0_rd_data", rd_data, 32'h1234);
    tick();
    chk("x0_rf", rf[0], 0);
    // reset mid-flight drops the captured write
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    tick();
    alu_valid = 1'b0;
    tick();
    chk("rf_x7_old", rf[7], 32'h77);
    alu_valid = 1'b1; alu_data = 32'hBAD;
    tick();
    alu_valid = 1'b0;
    chk("mid_wr_en_before", {31'b0, wr_en}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_wr_en", {31'b0, wr_en}, 0);
    chk("mid_rd_addr", {27'b0, rd_addr}, 0);
    chk("mid_rd_data", rd_data, 0);
    alu_valid = 1'b1;
    #1;
    chk("rst_alu_ready_comb", {31'b0, alu_ready}, 1);
    tick();
    chk("rst_no_handshake", {31'b0, wr_en}, 0);
    chk("rf_x7_kept", rf[7], 32'h77);
    alu_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {31'b0, wr_en}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
